aes_round_unit: RTL and testbench



---
 rtl/aes_round_unit_if.sv | 24 ++
 rtl/aes_round_unit.sv | 210 +++++++++++++++++++++
 tb/tb_aes_round_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_unit_if.sv
// rtl/aes_round_unit_if.sv - request/response bundle for the folded AES round unit

interface aes_round_unit_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic [127:0] in_key;
  logic         in_decrypt;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_state, in_key, in_decrypt, in_last, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_key, in_decrypt, in_last, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/aes_round_unit.sv
// rtl/aes_round_unit.sv - folded AES encrypt/decrypt round with LANES time-shared SBoxes

module aes_round_unit #(
  parameter int LANES = 4
) (
  input  logic clk,
  input  logic rst_n,
  aes_round_unit_if.slave bus
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
    $error("aes_round_unit: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, SUB, LIN, DONE} fsm_t;

  fsm_t          fsm;
  logic [127:0]  st;
  logic [127:0]  key_q;
  logic          dec_q;
  logic          last_q;
  logic [CW-1:0] cnt;
  logic          out_valid_q;
  logic          busy_q;
  logic          idle_q;
  logic [127:0]  sub_state;
  logic [127:0]  lin_state;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant using only xtime doublings.
  function automatic logic [7:0] mul_k(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{k[0]}} & a) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

  // General GF(2^8) product, shift-and-add over xtime.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0): x^127 by repeated square-multiply, then square.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] a;
    a = x;
    for (int i = 0; i < 6; i++) a = gf_mul(gf_mul(a, a), x);
    return gf_mul(a, a);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
  endfunction

  // Row r of column c takes the byte from column (c+r) (forward) or (c-r) (inverse).
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    int src;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        src = inv ? ((c - rr + 4) % 4) : ((c + rr) % 4);
        r[127-8*(4*c+rr) -: 8] = s[127-8*(4*src+rr) -: 8];
      end
    end
    return r;
  endfunction

  // Circulant matrix: output row r uses coefficient nibble j on input row (r+j) mod 4.
  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    logic [7:0]   a [4];
    logic [7:0]   acc;
    logic [15:0]  coef;
    r    = '0;
    coef = inv ? 16'hebd9 : 16'h2311;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127-8*(4*c+i) -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ mul_k(a[(rr+j)%4], coef[15-4*j -: 4]);
        r[127-8*(4*c+rr) -: 8] = acc;
      end
    end
    return r;
  endfunction

  // Substitute the LANES bytes selected by cnt; each lane shares one inverter between both directions.
  always_comb begin
    int         idx;
    logic [7:0] b;
    logic [7:0] g;
    sub_state = st;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(cnt) * LANES + l;
      b   = st[127-8*idx -: 8];
      g   = gf_inv(dec_q ? inv_affine(b) : b);
      sub_state[127-8*idx -: 8] = dec_q ? g : affine(g);
    end
  end

  // Linear layer plus key addition, ordered so decrypt exactly undoes encrypt.
  always_comb begin
    logic [127:0] t;
    t = '0;
    if (!dec_q) begin
      t = shift_rows(st, 1'b0);
      if (!last_q) t = mix_columns(t, 1'b0);
      lin_state = t ^ key_q;
    end else begin
      t = st ^ key_q;
      if (!last_q) t = mix_columns(t, 1'b1);
      lin_state = shift_rows(t, 1'b1);
    end
  end

  // Round sequencer with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      st          <= '0;
      key_q       <= '0;
      dec_q       <= 1'b0;
      last_q      <= 1'b0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      case (fsm)
        IDLE: begin
          if (bus.in_valid) begin
            st     <= bus.in_state;
            key_q  <= bus.in_key;
            dec_q  <= bus.in_decrypt;
            last_q <= bus.in_last;
            cnt    <= '0;
            busy_q <= 1'b1;
            idle_q <= 1'b0;
            fsm    <= bus.in_decrypt ? LIN : SUB;
          end
        end
        SUB: begin
          st <= sub_state;
          if (cnt == CW'(N - 1)) begin
            cnt <= '0;
            if (dec_q) begin
              fsm         <= DONE;
              out_valid_q <= 1'b1;
            end else begin
              fsm <= LIN;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LIN: begin
          st <= lin_state;
          if (dec_q) begin
            cnt <= '0;
            fsm <= SUB;
          end else begin
            fsm         <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            idle_q      <= 1'b1;
            fsm         <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // in_ready is forced low while reset is asserted and rises in the first cycle after it.
  assign bus.in_ready  = idle_q & rst_n;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = st;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_round_unit.sv
// tb/tb_aes_round_unit.sv - self-checking bench for aes_round_unit across all LANES values

module tb_aes_round_unit;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [4:0]   sel = 5'h1f;
  logic [127:0] in_state = '0;
  logic [127:0] in_key = '0;
  logic         in_decrypt = 1'b0;
  logic         in_last = 1'b0;
  logic         out_ready = 1'b0;

  logic [4:0]   ov, ir, bz;
  logic [127:0] os [5];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  localparam logic [7:0] MF [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01},
                                       '{8'h01, 8'h02, 8'h03, 8'h01},
                                       '{8'h01, 8'h01, 8'h02, 8'h03},
                                       '{8'h03, 8'h01, 8'h01, 8'h02}};
  localparam logic [7:0] MI [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
                                       '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                       '{8'h0d, 8'h09, 8'h0e, 8'h0b},
                                       '{8'h0b, 8'h0d, 8'h09, 8'h0e}};

  localparam logic [127:0] V1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] V1_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] V1_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] V2_IN  = 128'heb40f21e592e38848ba113e71bc342d2;
  localparam logic [127:0] V2_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] V2_OUT = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_dut
      aes_round_unit_if ifc ();
      assign ifc.in_valid   = in_valid & sel[gi];
      assign ifc.in_state   = in_state;
      assign ifc.in_key     = in_key;
      assign ifc.in_decrypt = in_decrypt;
      assign ifc.in_last    = in_last;
      assign ifc.out_ready  = out_ready & sel[gi];
      assign ov[gi] = ifc.out_valid;
      assign ir[gi] = ifc.in_ready;
      assign bz[gi] = ifc.busy;
      assign os[gi] = ifc.out_state;
      aes_round_unit #(.LANES(1 << gi)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
      );
    end
  endgenerate

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p, x, y;
    p = 0;
    x = int'(a);
    y = int'(b);
    for (int i = 0; i < 8; i++) begin
      if ((y & 1) != 0) p = p ^ x;
      x = x << 1;
      if ((x & 32'h100) != 0) x = x ^ 32'h11b;
      y = y >> 1;
    end
    return p[7:0];
  endfunction

  // SBox from the generator-3 walk over GF(2^8)*: p steps by 3, q steps by 1/3 = p^-1.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  // Reference round on a 16-byte array in FIPS-197 order.
  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k,
                                         input logic d, input logic l);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   acc;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8];
    if (!d) begin
      for (int i = 0; i < 16; i++) b[i] = sb[b[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[4*c+rr] = b[4*((c+rr)%4)+rr];
      if (!l) begin
        for (int c = 0; c < 4; c++)
          for (int rr = 0; rr < 4; rr++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(MF[rr][j], t[4*c+j]);
            b[4*c+rr] = acc;
          end
        for (int i = 0; i < 16; i++) t[i] = b[i];
      end
      for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
    end else begin
      for (int i = 0; i < 16; i++) b[i] = b[i] ^ k[127-8*i -: 8];
      if (!l) begin
        for (int c = 0; c < 4; c++)
          for (int rr = 0; rr < 4; rr++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(MI[rr][j], b[4*c+j]);
            t[4*c+rr] = acc;
          end
        for (int i = 0; i < 16; i++) b[i] = t[i];
      end
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[4*c+rr] = b[4*((c-rr+4)%4)+rr];
      for (int i = 0; i < 16; i++) t[i] = isb[t[i]];
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    step();
    step();
    n_checks++;
    if (ir !== 5'h00) begin n_fail++; $display("FAIL reset_in_ready got %b expected 00000", ir); end
    n_checks++;
    if (ov !== 5'h00 || bz !== 5'h00) begin n_fail++; $display("FAIL reset_valid_busy got %b/%b expected 0/0", ov, bz); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (os[i] !== 128'h0) begin n_fail++; $display("FAIL reset_out_state lanes=%0d got %h expected 0", 1 << i, os[i]); end
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ir !== 5'h1f) begin n_fail++; $display("FAIL reset_release_in_ready got %b expected 11111", ir); end
  endtask

  // Issue one request to the selected instances, measure latency and result, then drain.
  task automatic run_vector(input string name, input logic [4:0] m, input logic [127:0] s,
                            input logic [127:0] k, input logic d, input logic l,
                            input logic [127:0] exp);
    int lat [5];
    int cyc;
    sel = m;
    in_state = s;
    in_key = k;
    in_decrypt = d;
    in_last = l;
    out_ready = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_key = {$urandom, $urandom, $urandom, $urandom};
    in_decrypt = ~d;
    in_last = ~l;
    for (int i = 0; i < 5; i++) lat[i] = -1;
    cyc = 0;
    while (cyc <= 40) begin
      for (int i = 0; i < 5; i++)
        if (m[i] && ov[i] && lat[i] < 0) lat[i] = cyc;
      if ((ov & m) == m) break;
      step();
      cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      if (m[i]) begin
        n_checks++;
        if (lat[i] != (16 >> i) + 1) begin
          n_fail++;
          $display("FAIL %s latency lanes=%0d got %0d expected %0d", name, 1 << i, lat[i], (16 >> i) + 1);
        end
        n_checks++;
        if (os[i] !== exp) begin
          n_fail++;
          $display("FAIL %s result lanes=%0d got %h expected %h", name, 1 << i, os[i], exp);
        end
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if ((ov & m) !== 5'h00 || (ir & m) !== m) begin
      n_fail++;
      $display("FAIL %s drain valid=%b ready=%b expected valid=0 ready=%b", name, ov & m, ir & m, m);
    end
  endtask

  task automatic test_vectors();
    run_vector("enc_round", 5'h1f, V1_IN, V1_KEY, 1'b0, 1'b0, V1_OUT);
    run_vector("enc_last", 5'h1f, V2_IN, V2_KEY, 1'b0, 1'b1, V2_OUT);
    run_vector("dec_round", 5'h1f, V1_OUT, V1_KEY, 1'b1, 1'b0, V1_IN);
    run_vector("dec_last", 5'h1f, V2_OUT, V2_KEY, 1'b1, 1'b1, V2_IN);
  endtask

  task automatic test_backpressure();
    int cyc;
    sel = 5'b00100;
    in_state = V1_IN;
    in_key = V1_KEY;
    in_decrypt = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!ov[2] && cyc < 20) begin step(); cyc++; end
    n_checks++;
    if (!ov[2]) begin n_fail++; $display("FAIL bp_wait out_valid got 0 expected 1"); end
    in_valid = 1'b1;
    in_state = V2_IN;
    in_key = V2_KEY;
    in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (ov[2] !== 1'b1 || os[i % 1 + 2] !== V1_OUT || ir[2] !== 1'b0 || bz[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold cycle=%0d valid=%b ready=%b busy=%b state=%h expected 1/0/1 %h",
                 i, ov[2], ir[2], bz[2], os[2], V1_OUT);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (ov[2] !== 1'b0 || ir[2] !== 1'b1 || bz[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release valid=%b ready=%b busy=%b expected 0/1/0", ov[2], ir[2], bz[2]);
    end
    for (int i = 0; i < 8; i++) step();
    n_checks++;
    if (ov[2] !== 1'b0 || bz[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_second valid=%b busy=%b expected 0/0", ov[2], bz[2]);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    sel = 5'b00001;
    in_state = V1_IN;
    in_key = V1_KEY;
    in_decrypt = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ov[0] !== 1'b0 || os[0] !== 128'h0 || bz[0] !== 1'b0 || ir[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid valid=%b busy=%b ready=%b state=%h expected 0/0/1 0", ov[0], bz[0], ir[0], os[0]);
    end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ov[0]) seen = 1'b1;
      step();
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL reset_mid_pulse got out_valid=1 expected none"); end
    out_ready = 1'b0;
    run_vector("after_reset", 5'h1f, V2_IN, V2_KEY, 1'b0, 1'b1, V2_OUT);
  endtask

  task automatic new_req();
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_key = {$urandom, $urandom, $urandom, $urandom};
    in_decrypt = 1'($urandom_range(0, 1));
    in_last = 1'($urandom_range(0, 1));
  endtask

  task automatic test_random();
    logic [127:0] q [$];
    logic [127:0] cap, e;
    logic acc, hs;
    int results, cyc;
    sel = 5'b00100;
    new_req();
    results = 0;
    cyc = 0;
    while (results < 1000 && cyc < 40000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      acc = in_valid && ir[2];
      hs = ov[2] && out_ready;
      cap = os[2];
      step();
      cyc++;
      if (acc) begin
        q.push_back(model(in_state, in_key, in_decrypt, in_last));
        new_req();
      end
      if (hs) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_extra result=%h expected none outstanding", cap);
        end else begin
          e = q.pop_front();
          if (cap !== e) begin
            n_fail++;
            $display("FAIL rand_result n=%0d got %h expected %h", results, cap, e);
          end
        end
        results++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (results < 1000) begin n_fail++; $display("FAIL rand_timeout got %0d results expected 1000", results); end
    n_checks++;
    if (q.size() > 1) begin n_fail++; $display("FAIL rand_lost got %0d pending expected at most 1", q.size()); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
